// File: rtl/rv32_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : rv32_dmem_responder
// Purpose  : Bridges an RV32 CPU data port to a single-beat backing memory.
//            Aligned requests go to the memory port combinationally in the
//            same cycle. A zero-wait mem_ack completes in that cycle.
//            Otherwise the request is captured and held in WAIT until mem_ack
//            arrives. Misaligned requests never reach memory. They produce a
//            one-cycle err pulse instead.
// Config   : `define DMEM_TIMEOUT_EN to compile in a WAIT-state watchdog.
//            After TIMEOUT WAIT cycles without mem_ack it aborts the access,
//            pulses err and returns ERR_DATA on loads.
// Ports    : clk, rst (async, active-high)
//            CPU side : data_enable, data_read, data_addr[31:0],
//                       data_store[31:0] -> data_fetch[31:0], busy, err
//            Mem side : mem_req, mem_we, mem_addr[29:0], mem_wdata[31:0]
//                       <- mem_rdata[31:0], mem_ack
// Revision : 1.0 - initial release
// ============================================================================
module rv32_dmem_responder #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_enable,
  input  logic        data_read,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_store,
  output logic [31:0] data_fetch,
  output logic        busy,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        rd_q, rd_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_fetch_q, data_fetch_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic        w_req;
  logic        w_we;
  logic [29:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_aligned;

  assign w_aligned = (data_addr[1:0] == 2'b00);

`ifdef DMEM_TIMEOUT_EN
  localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
`else
  // Parameters only matter when the watchdog is compiled in.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{ERR_DATA, 8'(TIMEOUT)};
`endif

  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    data_fetch_d = data_fetch_q;
    busy_d       = 1'b0;
    err_d        = 1'b0;
    w_req        = 1'b0;
    w_we         = 1'b0;
    w_addr       = '0;
    w_wdata      = '0;
`ifdef DMEM_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (data_enable) begin
          if (w_aligned) begin
            w_req   = 1'b1;
            w_we    = ~data_read;
            w_addr  = data_addr[31:2];
            w_wdata = data_store;
            if (mem_ack) begin
              if (data_read) data_fetch_d = mem_rdata;
            end else begin
              rd_d    = data_read;
              addr_d  = data_addr[31:2];
              wdata_d = data_store;
              state_d = S_WAIT;
              busy_d  = 1'b1;
`ifdef DMEM_TIMEOUT_EN
              cnt_d   = '0;
`endif
            end
          end else begin
            // Misaligned: never touches memory, error reported next cycle.
            err_d = 1'b1;
            if (data_read) data_fetch_d = '0;
          end
        end
      end
      S_WAIT: begin
        // CPU inputs are ignored here; the port replays the captured request.
        w_req   = 1'b1;
        w_we    = ~rd_q;
        w_addr  = addr_q;
        w_wdata = wdata_q;
        if (mem_ack) begin
          // A completion wins over a timeout that expires in the same cycle.
          if (rd_q) data_fetch_d = mem_rdata;
          state_d = S_IDLE;
        end else begin
`ifdef DMEM_TIMEOUT_EN
          if (cnt_q == C_TIMEOUT_LAST) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            if (rd_q) data_fetch_d = ERR_DATA;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            busy_d = 1'b1;
          end
`else
          busy_d = 1'b1;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rd_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      data_fetch_q <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      data_fetch_q <= data_fetch_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  // The memory port is combinational, so it is forced quiet while rst is
  // high rather than waiting for the state flops to settle.
  assign mem_req    = w_req & ~rst;
  assign mem_we     = w_we & ~rst;
  assign mem_addr   = rst ? 30'd0 : w_addr;
  assign mem_wdata  = rst ? 32'd0 : w_wdata;
  assign data_fetch = data_fetch_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_dmem_responder
// Purpose  : Directed self-checking bench for rv32_dmem_responder. Expected
//            load results are queued when a request is issued and popped
//            when the transaction completes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_enable;
  logic        data_read;
  logic [31:0] data_addr;
  logic [31:0] data_store;
  logic [31:0] data_fetch;
  logic        busy;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  rv32_dmem_responder #(.TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst),
    .data_enable(data_enable), .data_read(data_read),
    .data_addr(data_addr), .data_store(data_store),
    .data_fetch(data_fetch), .busy(busy), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compares data_fetch against the oldest queued expectation.
  task automatic chk_fetch(input string tag);
    logic [31:0] e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, data_fetch);
    end else begin
      e = sb.pop_front();
      chk(tag, data_fetch, e);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic rd, input logic [31:0] a,
                       input logic [31:0] st, input logic ack, input logic [31:0] rdat);
    data_enable = en;
    data_read   = rd;
    data_addr   = a;
    data_store  = st;
    mem_ack     = ack;
    mem_rdata   = rdat;
  endtask

  initial begin
    // Reset with a live aligned request: memory port must stay quiet.
    rst = 1'b1;
    drive(1'b1, 1'b1, 32'h0000_0100, 32'h1, 1'b0, 32'h0);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_fetch", data_fetch, 32'd0);
    cyc;
    cyc;
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0123, 1'b0, 32'h0);
    #1;
    chk("idle_req", 32'(mem_req), 32'd0);
    chk("idle_we", 32'(mem_we), 32'd0);
    chk("idle_addr", 32'(mem_addr), 32'd0);
    chk("idle_wdata", mem_wdata, 32'd0);

    // Zero-wait load.
    cyc;
    drive(1'b1, 1'b1, 32'h0000_0100, 32'h0, 1'b1, 32'h1234_5678);
    sb.push_back(32'h1234_5678);
    #1;
    chk("zw_req", 32'(mem_req), 32'd1);
    chk("zw_we", 32'(mem_we), 32'd0);
    chk("zw_addr", 32'(mem_addr), 32'h40);
    cyc;
    chk("zw_busy", 32'(busy), 32'd0);
    chk_fetch("zw_fetch");
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Two-wait store; CPU inputs change during WAIT and must be ignored.
    cyc;
    drive(1'b1, 1'b0, 32'h0000_0204, 32'hCAFE_F00D, 1'b0, 32'h0);
    #1;
    chk("st_we", 32'(mem_we), 32'd1);
    chk("st_wdata", mem_wdata, 32'hCAFE_F00D);
    cyc;
    drive(1'b1, 1'b1, 32'h0000_0998, 32'h0, 1'b0, 32'h0);
    #1;
    chk("st_w1_busy", 32'(busy), 32'd1);
    chk("st_w1_req", 32'(mem_req), 32'd1);
    chk("st_w1_we", 32'(mem_we), 32'd1);
    chk("st_w1_addr", 32'(mem_addr), 32'h81);
    chk("st_w1_wdata", mem_wdata, 32'hCAFE_F00D);
    cyc;
    mem_ack = 1'b1;
    #1;
    chk("st_w2_busy", 32'(busy), 32'd1);
    chk("st_w2_wdata", mem_wdata, 32'hCAFE_F00D);
    cyc;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("st_done_busy", 32'(busy), 32'd0);
    chk("st_fetch_kept", data_fetch, 32'h1234_5678);

    // One-wait load.
    cyc;
    drive(1'b1, 1'b1, 32'h0000_0300, 32'h0, 1'b0, 32'h0);
    cyc;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hA5A5_0001);
    sb.push_back(32'hA5A5_0001);
    #1;
    chk("ld1_addr", 32'(mem_addr), 32'hC0);
    cyc;
    mem_ack = 1'b0;
    chk_fetch("ld1_fetch");
    chk("ld1_busy", 32'(busy), 32'd0);

    // Misaligned load; mem_ack is offered but must not matter.
    cyc;
    drive(1'b1, 1'b1, 32'h0000_0103, 32'h0, 1'b1, 32'h7777_7777);
    sb.push_back(32'h0);
    #1;
    chk("mis_req", 32'(mem_req), 32'd0);
    cyc;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("mis_err", 32'(err), 32'd1);
    chk_fetch("mis_fetch");
    chk("mis_busy", 32'(busy), 32'd0);
    cyc;
    chk("mis_err_once", 32'(err), 32'd0);

    // Back-to-back zero-wait loads.
    drive(1'b1, 1'b1, 32'h0000_0010, 32'h0, 1'b1, 32'h1111_1111);
    sb.push_back(32'h1111_1111);
    cyc;
    chk_fetch("b2b_fetch0");
    drive(1'b1, 1'b1, 32'h0000_0014, 32'h0, 1'b1, 32'h2222_2222);
    sb.push_back(32'h2222_2222);
    #1;
    chk("b2b_req1", 32'(mem_req), 32'd1);
    chk("b2b_addr1", 32'(mem_addr), 32'h5);
    cyc;
    chk_fetch("b2b_fetch1");

    // Stray ack with no request.
    drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 32'hFFFF_0000);
    #1;
    chk("stray_req", 32'(mem_req), 32'd0);
    cyc;
    chk("stray_fetch", data_fetch, 32'h2222_2222);
    chk("stray_busy", 32'(busy), 32'd0);

    // Reset on the second WAIT cycle.
    drive(1'b1, 1'b1, 32'h0000_0400, 32'h0, 1'b0, 32'h0);
    cyc;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    cyc;
    rst = 1'b1;
    #1;
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_req", 32'(mem_req), 32'd0);
    chk("rw_err", 32'(err), 32'd0);
    chk("rw_fetch", data_fetch, 32'd0);
    cyc;
    rst = 1'b0;
    cyc;
    chk("rw_err_after", 32'(err), 32'd0);
    drive(1'b1, 1'b1, 32'h0000_0008, 32'h0, 1'b1, 32'h5555_AAAA);
    sb.push_back(32'h5555_AAAA);
    #1;
    chk("rw_next_addr", 32'(mem_addr), 32'h2);
    cyc;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk_fetch("rw_next_fetch");

`ifdef DMEM_TIMEOUT_EN
    // Load that never gets an ack: 16 WAIT cycles, then abort.
    cyc;
    drive(1'b1, 1'b1, 32'h0000_0500, 32'h0, 1'b0, 32'h0);
    sb.push_back(32'hDEAD_BEEF);
    cyc;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("to_req_%0d", i), 32'(mem_req), 32'd1);
      chk($sformatf("to_busy_%0d", i), 32'(busy), 32'd1);
      cyc;
    end
    chk("to_req_drop", 32'(mem_req), 32'd0);
    chk("to_err", 32'(err), 32'd1);
    chk("to_busy_low", 32'(busy), 32'd0);
    chk_fetch("to_fetch");
    cyc;
    chk("to_err_once", 32'(err), 32'd0);

    // Ack in the final WAIT cycle wins over the timeout.
    drive(1'b1, 1'b1, 32'h0000_0600, 32'h0, 1'b0, 32'h0);
    cyc;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 15; i++) cyc;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    sb.push_back(32'h0BAD_F00D);
    cyc;
    mem_ack = 1'b0;
    chk("tp_err", 32'(err), 32'd0);
    chk("tp_busy", 32'(busy), 32'd0);
    chk_fetch("tp_fetch");
`else
    // Without the watchdog a missing ack keeps the block busy.
    cyc;
    drive(1'b1, 1'b1, 32'h0000_0500, 32'h0, 1'b0, 32'h0);
    cyc;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 40; i++) cyc;
    chk("nt_busy", 32'(busy), 32'd1);
    chk("nt_req", 32'(mem_req), 32'd1);
    chk("nt_err", 32'(err), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    sb.push_back(32'h0BAD_F00D);
    cyc;
    mem_ack = 1'b0;
    chk("nt_busy_low", 32'(busy), 32'd0);
    chk_fetch("nt_fetch");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
